spi_req_arbiter: RTL and testbench

- Two-requester arbiter sharing the single SPI engine command port (11-bit din, cmd/wr/rd strobes, 9-bit dout, ack) between independent masters, e.g. the wishbone_if bridge and a boot/config sequencer.
- Sits between the requesters and spi_if.
- Round-robin grant, optional lock to keep ownership across multi-byte transfers, and a watchdog that aborts hung transactions.

---
 rtl/spi_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Two-requester round-robin arbiter in front of the SPI engine command port.
// Supports a lock to keep ownership across transfers and a watchdog on spi_ack.
module spi_req_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] r0_din,
    input  logic        r0_cmd,
    input  logic        r0_wr,
    input  logic        r0_rd,
    input  logic        r0_lock,
    output logic [8:0]  r0_dout,
    output logic        r0_ack,
    output logic        r0_err,
    input  logic [10:0] r1_din,
    input  logic        r1_cmd,
    input  logic        r1_wr,
    input  logic        r1_rd,
    input  logic        r1_lock,
    output logic [8:0]  r1_dout,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [10:0] spi_din,
    output logic        spi_cmd,
    output logic        spi_wr,
    output logic        spi_rd,
    input  logic [8:0]  spi_dout,
    input  logic        spi_ack,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [TW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [10:0]   spi_din_q, spi_din_d;
    logic          spi_cmd_q, spi_cmd_d;
    logic          spi_wr_q, spi_wr_d;
    logic          spi_rd_q, spi_rd_d;
    logic [8:0]    r0_dout_q, r0_dout_d;
    logic [8:0]    r1_dout_q, r1_dout_d;

    logic stb0, stb1;
    logic own, own_stb, own_lock;
    logic issue, sel;

    always_comb begin
        stb0     = r0_cmd | r0_wr | r0_rd;
        stb1     = r1_cmd | r1_wr | r1_rd;
        own      = grant_q[1];
        own_stb  = own ? stb1 : stb0;
        own_lock = own ? r1_lock : r0_lock;

        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        lock_d    = lock_q;
        err_d     = err_q;
        wd_d      = '0;
        spi_din_d = spi_din_q;
        spi_cmd_d = spi_cmd_q;
        spi_wr_d  = spi_wr_q;
        spi_rd_d  = spi_rd_q;
        r0_dout_d = r0_dout_q;
        r1_dout_d = r1_dout_q;
        issue     = 1'b0;
        sel       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // on contention the requester that did not go last wins
                if (stb0 && (!stb1 || last_q)) begin
                    issue = 1'b1;
                    sel   = 1'b0;
                end else if (stb1) begin
                    issue = 1'b1;
                    sel   = 1'b1;
                end
            end
            S_WAIT: begin
                if (spi_ack) begin
                    if (own) r1_dout_d = spi_dout;
                    else     r0_dout_d = spi_dout;
                    err_d     = 1'b0;
                    spi_din_d = '0;
                    spi_cmd_d = 1'b0;
                    spi_wr_d  = 1'b0;
                    spi_rd_d  = 1'b0;
                    state_d   = S_DONE;
                end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
                    if (own) r1_dout_d = '1;
                    else     r0_dout_d = '1;
                    err_d     = 1'b1;
                    spi_din_d = '0;
                    spi_cmd_d = 1'b0;
                    spi_wr_d  = 1'b0;
                    spi_rd_d  = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            S_DONE: begin
                err_d = 1'b0;
                if (lock_q) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_HOLD: begin
                if (own_stb) begin
                    issue = 1'b1;
                    sel   = own;
                end else if (!own_lock) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (issue) begin
            state_d   = S_WAIT;
            grant_d   = sel ? 2'b10 : 2'b01;
            last_d    = sel;
            lock_d    = sel ? r1_lock : r0_lock;
            err_d     = 1'b0;
            spi_din_d = sel ? r1_din : r0_din;
            spi_cmd_d = sel ? r1_cmd : r0_cmd;
            spi_wr_d  = sel ? r1_wr  : r0_wr;
            spi_rd_d  = sel ? r1_rd  : r0_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            wd_q      <= '0;
            spi_din_q <= '0;
            spi_cmd_q <= 1'b0;
            spi_wr_q  <= 1'b0;
            spi_rd_q  <= 1'b0;
            r0_dout_q <= '0;
            r1_dout_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
            spi_din_q <= spi_din_d;
            spi_cmd_q <= spi_cmd_d;
            spi_wr_q  <= spi_wr_d;
            spi_rd_q  <= spi_rd_d;
            r0_dout_q <= r0_dout_d;
            r1_dout_q <= r1_dout_d;
        end
    end

    assign spi_din = spi_din_q;
    assign spi_cmd = spi_cmd_q;
    assign spi_wr  = spi_wr_q;
    assign spi_rd  = spi_rd_q;
    assign grant   = grant_q;
    assign busy    = (state_q == S_WAIT) || (state_q == S_DONE);
    assign r0_dout = r0_dout_q;
    assign r1_dout = r1_dout_q;
    assign r0_ack  = (state_q == S_DONE) && grant_q[0];
    assign r1_ack  = (state_q == S_DONE) && grant_q[1];
    assign r0_err  = r0_ack && err_q;
    assign r1_err  = r1_ack && err_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_spi_req_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic [10:0] din  [2];
    logic [2:0]  strb [2];   // {cmd, wr, rd}
    logic        lock [2];
    logic [8:0]  spi_dout;
    logic        spi_ack;

    logic [8:0]  r0_dout, r1_dout;
    logic        r0_ack, r1_ack, r0_err, r1_err;
    logic [10:0] spi_din;
    logic        spi_cmd, spi_wr, spi_rd;
    logic [1:0]  grant;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         m_last;
    int         m_hold;
    logic [8:0] m_dout [2];

    spi_req_arbiter #(.TIMEOUT(TO), .TW(4)) dut (
        .clk(clk), .rst(rst),
        .r0_din(din[0]), .r0_cmd(strb[0][2]), .r0_wr(strb[0][1]), .r0_rd(strb[0][0]),
        .r0_lock(lock[0]), .r0_dout(r0_dout), .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_din(din[1]), .r1_cmd(strb[1][2]), .r1_wr(strb[1][1]), .r1_rd(strb[1][0]),
        .r1_lock(lock[1]), .r1_dout(r1_dout), .r1_ack(r1_ack), .r1_err(r1_err),
        .spi_din(spi_din), .spi_cmd(spi_cmd), .spi_wr(spi_wr), .spi_rd(spi_rd),
        .spi_dout(spi_dout), .spi_ack(spi_ack),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] exp_grant();
        return (m_hold >= 0) ? onehot(m_hold) : 2'b00;
    endfunction

    function automatic int pick();
        bit s0, s1;
        s0 = |strb[0];
        s1 = |strb[1];
        if (m_hold >= 0) return ((m_hold == 0 ? s0 : s1) ? m_hold : -1);
        if (s0 && s1) return (m_last == 0) ? 1 : 0;
        if (s0) return 0;
        if (s1) return 1;
        return -1;
    endfunction

    function automatic logic [2:0] rand_strb();
        logic [2:0] s;
        s = 3'b001;
        return s << $urandom_range(0, 2);
    endfunction

    // Idle/hold cycle: nothing in flight, grant only reflects a held lock.
    task automatic quiet_chk();
        @(negedge clk);
        chk("q_grant", 32'(grant), 32'(exp_grant()));
        chk("q_busy", 32'(busy), 0);
        chk("q_spi", 32'({spi_din, spi_cmd, spi_wr, spi_rd}), 0);
        chk("q_ack", 32'({r0_ack, r1_ack, r0_err, r1_err}), 0);
        chk("q_dout0", 32'(r0_dout), 32'(m_dout[0]));
        chk("q_dout1", 32'(r1_dout), 32'(m_dout[1]));
    endtask

    // A cycle in which no grant is expected; a released lock returns to idle.
    task automatic gap();
        if (m_hold >= 0 && !lock[m_hold] && strb[m_hold] == 3'b000) m_hold = -1;
        quiet_chk();
    endtask

    // Full transaction from an arbitration cycle; ack_at < 0 means the engine never acks.
    task automatic txn(input int ack_at, input logic [8:0] rdata, input bit rearm);
        int          w;
        logic [10:0] edin;
        logic [2:0]  estb;
        bit          elock;
        bit          tmo;
        int          wlen;
        w     = pick();
        edin  = din[w];
        estb  = strb[w];
        elock = lock[w];
        tmo   = (ack_at < 0) || (ack_at > TO - 1);
        wlen  = tmo ? TO : ack_at + 1;
        for (int j = 0; j < wlen; j++) begin
            @(negedge clk);
            chk("w_grant", 32'(grant), 32'(onehot(w)));
            chk("w_busy", 32'(busy), 1);
            chk("w_din", 32'(spi_din), 32'(edin));
            chk("w_strb", 32'({spi_cmd, spi_wr, spi_rd}), 32'(estb));
            chk("w_ack", 32'({r0_ack, r1_ack, r0_err, r1_err}), 0);
            chk("w_dout", 32'({r1_dout, r0_dout}), 32'({m_dout[1], m_dout[0]}));
            if (!tmo && j == ack_at) begin
                spi_ack  = 1'b1;
                spi_dout = rdata;
            end else begin
                spi_dout = 9'($urandom);
            end
        end
        @(negedge clk);
        spi_ack  = 1'b0;
        spi_dout = 9'($urandom);
        m_dout[w] = tmo ? 9'h1FF : rdata;
        chk("d_grant", 32'(grant), 32'(onehot(w)));
        chk("d_busy", 32'(busy), 1);
        chk("d_spi", 32'({spi_din, spi_cmd, spi_wr, spi_rd}), 0);
        chk("d_ack", 32'({r1_ack, r0_ack}), 32'(onehot(w)));
        chk("d_err", 32'({r1_err, r0_err}), tmo ? 32'(onehot(w)) : 0);
        chk("d_dout", 32'({r1_dout, r0_dout}), 32'({m_dout[1], m_dout[0]}));
        m_last = w;
        m_hold = elock ? w : -1;
        if (rearm) begin
            strb[w] = rand_strb();
            din[w]  = 11'($urandom);
        end else begin
            strb[w] = 3'b000;
        end
    endtask

    task automatic model_reset();
        m_last    = 1;
        m_hold    = -1;
        m_dout[0] = '0;
        m_dout[1] = '0;
    endtask

    initial begin
        rst      = 1'b0;
        spi_ack  = 1'b0;
        spi_dout = '0;
        for (int i = 0; i < 2; i++) begin
            din[i]  = '0;
            strb[i] = '0;
            lock[i] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_out", 32'({grant, busy, spi_din, spi_cmd, spi_wr, spi_rd}), 0);
        chk("rst_r", 32'({r0_ack, r0_err, r1_ack, r1_err, r0_dout, r1_dout}), 0);
        rst = 1'b1;

        // single write, engine acks three cycles after spi_wr appears
        din[0]  = 11'h0A5;
        strb[0] = 3'b010;
        txn(3, 9'h055, 1'b0);
        quiet_chk();

        // round robin under permanent contention
        din[0]  = 11'h111;
        din[1]  = 11'h222;
        strb[0] = 3'b001;
        strb[1] = 3'b001;
        txn(1, 9'h13C, 1'b1);
        quiet_chk();
        txn(0, 9'h042, 1'b1);
        quiet_chk();
        txn(2, 9'h0F0, 1'b1);
        quiet_chk();
        txn(4, 9'h10F, 1'b1);
        strb[0] = 3'b000;
        strb[1] = 3'b000;
        quiet_chk();

        // locked multi-transfer on r1 while r0 waits
        lock[1] = 1'b1;
        strb[1] = 3'b010;
        din[1]  = 11'h3C3;
        txn(1, 9'h001, 1'b1);
        strb[0] = 3'b100;
        din[0]  = 11'h7FF;
        strb[1] = 3'b010;
        quiet_chk();
        txn(2, 9'h002, 1'b1);
        strb[1] = 3'b010;
        quiet_chk();
        txn(0, 9'h003, 1'b0);
        lock[1] = 1'b0;
        quiet_chk();
        gap();
        txn(1, 9'h0AA, 1'b0);
        quiet_chk();

        // watchdog abort, then a normal transfer
        strb[0] = 3'b001;
        din[0]  = 11'h400;
        txn(-1, 9'h000, 1'b0);
        quiet_chk();
        strb[1] = 3'b010;
        din[1]  = 11'h155;
        txn(2, 9'h0CC, 1'b0);
        quiet_chk();

        // ack exactly on the last watchdog cycle wins over the abort
        strb[0] = 3'b001;
        din[0]  = 11'h2AA;
        txn(TO - 1, 9'h0B7, 1'b0);
        quiet_chk();

        // reset in the middle of WAIT
        strb[0] = 3'b001;
        din[0]  = 11'h3F0;
        @(negedge clk);
        chk("rw_grant", 32'(grant), 32'(2'b01));
        rst     = 1'b0;
        spi_ack = 1'b1;
        @(negedge clk);
        chk("rw_out", 32'({grant, busy, spi_din, spi_cmd, spi_wr, spi_rd}), 0);
        chk("rw_r", 32'({r0_ack, r0_err, r1_ack, r1_err, r0_dout, r1_dout}), 0);
        spi_ack = 1'b0;
        rst     = 1'b1;
        model_reset();
        strb[0] = 3'b010;
        strb[1] = 3'b010;
        din[1]  = 11'h0E1;
        txn(2, 9'h1E1, 1'b0);
        quiet_chk();
        txn(1, 9'h0E2, 1'b0);
        quiet_chk();

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 2; i++) begin
                strb[i] = ($urandom_range(0, 9) < 7) ? rand_strb() : 3'b000;
                din[i]  = 11'($urandom);
                lock[i] = ($urandom_range(0, 3) == 0);
            end
            if (pick() >= 0) begin
                txn(($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO)),
                    9'($urandom), 1'b0);
                quiet_chk();
            end else begin
                gap();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
